pixel_controller: RTL and testbench

PIXEL_CONTROLLER -- requirements
Module: pixel_controller

---
 rtl/pixel_controller.sv | 121 ++++++++++++
 tb/tb_pixel_controller.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_controller.sv
// pixel_controller -- free-running 8-digit anode scanner for a multiplexed
// seven-segment display. One digit is enabled per scan clock; a full sweep
// takes 8 clocks (60 Hz per digit at 480 Hz).
//
// Ports:
//   clk_480Hz  in   scan clock; every state change happens on its rising edge
//   reset      in   asynchronous, active-high; forces S0 (digit 0 enabled)
//   a7..a0     out  digit anode enables, a0 = rightmost digit (registered)
//   seg_sel    out  index of the enabled digit for the digit-data mux (registered)
//   state_dbg  out  raw FSM state register (one-hot, or zero-extended binary)
//
// Parameter:
//   ANODE_ACTIVE_LOW  1: selected anode driven 0, others 1; 0: inverted.
//
// Build option:
//   PIX_CTRL_SAFE_FSM_EN  defined   -> 8-bit one-hot state; any illegal pattern
//                                      returns to S0 on the next rising edge.
//                         undefined -> 3-bit binary state; all codes legal.
//
// Interface note: there is no handshake; the block runs whenever reset is low.
module pixel_controller #(
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_480Hz,
    input  logic       reset,
    output logic       a7,
    output logic       a6,
    output logic       a5,
    output logic       a4,
    output logic       a3,
    output logic       a2,
    output logic       a1,
    output logic       a0,
    output logic [2:0] seg_sel,
    output logic [7:0] state_dbg
);

`ifdef PIX_CTRL_SAFE_FSM_EN
    typedef enum logic [7:0] {
        S0 = 8'b0000_0001,
        S1 = 8'b0000_0010,
        S2 = 8'b0000_0100,
        S3 = 8'b0000_1000,
        S4 = 8'b0001_0000,
        S5 = 8'b0010_0000,
        S6 = 8'b0100_0000,
        S7 = 8'b1000_0000
    } state_t;
`else
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;
`endif

    state_t     state;
    state_t     next_state;
    logic [2:0] next_idx;
    logic [7:0] anode_q;

    // Anode pattern for digit idx with the configured polarity applied.
    function automatic logic [7:0] anode_pattern(input logic [2:0] idx);
        logic [7:0] onehot;
        onehot = 8'b0000_0001 << idx;
        return ANODE_ACTIVE_LOW ? ~onehot : onehot;
    endfunction

    localparam logic [7:0] RESET_ANODES = anode_pattern(3'd0);

`ifdef PIX_CTRL_SAFE_FSM_EN
    // Any pattern that is not exactly one-hot falls into default and recovers.
    always_comb begin
        next_state = S0;
        next_idx   = 3'd0;
        case (state)
            S0:      begin next_state = S1; next_idx = 3'd1; end
            S1:      begin next_state = S2; next_idx = 3'd2; end
            S2:      begin next_state = S3; next_idx = 3'd3; end
            S3:      begin next_state = S4; next_idx = 3'd4; end
            S4:      begin next_state = S5; next_idx = 3'd5; end
            S5:      begin next_state = S6; next_idx = 3'd6; end
            S6:      begin next_state = S7; next_idx = 3'd7; end
            S7:      begin next_state = S0; next_idx = 3'd0; end
            default: begin next_state = S0; next_idx = 3'd0; end
        endcase
    end

    assign state_dbg = state;
`else
    // Binary encoding: the state code is the digit index, wrap is natural.
    always_comb begin
        next_idx   = state + 3'd1;
        next_state = state_t'(next_idx);
    end

    assign state_dbg = {5'b0_0000, state};
`endif

    // Outputs are loaded from the next-state index on the same edge as the
    // state, so they are registered and always agree with each other.
    always_ff @(posedge clk_480Hz or posedge reset) begin
        if (reset) begin
            state   <= S0;
            seg_sel <= 3'd0;
            anode_q <= RESET_ANODES;
        end else begin
            state   <= next_state;
            seg_sel <= next_idx;
            anode_q <= anode_pattern(next_idx);
        end
    end

    assign {a7, a6, a5, a4, a3, a2, a1, a0} = anode_q;

endmodule

// File: tb/tb_pixel_controller.sv
// Self-checking bench for pixel_controller (default parameters).
module tb_pixel_controller;

    logic       clk_480Hz;
    logic       reset;
    logic       clk_run;
    logic       a7, a6, a5, a4, a3, a2, a1, a0;
    logic [2:0] seg_sel;
    logic [7:0] state_dbg;
    logic [7:0] anodes;

    int n_checks;
    int n_pass;

    // Reference model: index of the digit the DUT should currently enable.
    logic [2:0]  model_idx;
    // Expected {seg_sel, anodes} entries, pushed on drive, popped on sample.
    logic [10:0] exp_q[$];

    pixel_controller #(.ANODE_ACTIVE_LOW(1'b1)) dut (
        .clk_480Hz (clk_480Hz),
        .reset     (reset),
        .a7        (a7),
        .a6        (a6),
        .a5        (a5),
        .a4        (a4),
        .a3        (a3),
        .a2        (a2),
        .a1        (a1),
        .a0        (a0),
        .seg_sel   (seg_sel),
        .state_dbg (state_dbg)
    );

    assign anodes = {a7, a6, a5, a4, a3, a2, a1, a0};

    // ---------------- clock / reset ----------------
    // Clock toggles every 5 ns only while clk_run is set, so it can be parked
    // low or high.
    initial clk_480Hz = 1'b0;
    always begin
        #5;
        if (clk_run) clk_480Hz = ~clk_480Hz;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    // Expected active-low anode vector for digit idx, built bit by bit.
    function automatic logic [7:0] exp_anodes(input logic [2:0] idx);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = (i == int'(idx)) ? 1'b0 : 1'b1;
        return v;
    endfunction

    task automatic check_now(input string tag, input logic [2:0] idx);
        check({tag, "_seg"}, {29'd0, seg_sel}, {29'd0, idx});
        check({tag, "_an"}, {24'd0, anodes}, {24'd0, exp_anodes(idx)});
    endtask

    // ---------------- driver ----------------
    // One rising edge: predict, push, wait, sample 1 ns later, pop and compare.
    task automatic step();
        logic [10:0] e;
        model_idx = model_idx + 3'd1;
        exp_q.push_back({model_idx, exp_anodes(model_idx)});
        @(posedge clk_480Hz);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("sb_seg", {29'd0, seg_sel}, {29'd0, e[10:8]});
            check("sb_an", {24'd0, anodes}, {24'd0, e[7:0]});
            check("sb_onehot", $countones(~anodes), 32'd1);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Assert reset away from any edge, hold it over two edges, release.
    task automatic mid_scan_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_now({tag, "_async"}, 3'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_480Hz);
            #1;
            check_now({tag, "_hold"}, 3'd0);
        end
        @(negedge clk_480Hz);
        #2;
        reset = 1'b0;
        model_idx = 3'd0;
    endtask

    // ---------------- sequence ----------------
    initial begin
        n_checks  = 0;
        n_pass    = 0;
        model_idx = 3'd0;
        clk_run   = 1'b0;
        reset     = 1'b0;

        // 10 ns reset pulse with the clock parked low: no edge involved.
        #3;
        reset = 1'b1;
        #5;
        check_now("rst_pulse", 3'd0);
        #5;
        reset = 1'b0;
        #2;
        check_now("rst_release", 3'd0);

        // One full sweep and the wrap back to digit 0.
        clk_run = 1'b1;
        steps(8);
        check_now("sweep_wrap", 3'd0);

        // Two more full sweeps.
        steps(16);
        check_now("two_cycles", 3'd0);

        // Run to S5, then reset asynchronously mid-scan.
        steps(5);
        check("pre_rst_s5", {29'd0, seg_sel}, 32'd5);
        mid_scan_reset("rst_s5");
        step();
        check("first_after_rst", {29'd0, seg_sel}, 32'd1);

        // Clock parked low, then parked high: outputs must not move.
        @(negedge clk_480Hz);
        clk_run = 1'b0;
        #50;
        check_now("hold_low", model_idx);
        clk_run = 1'b1;
        step();
        clk_run = 1'b0;
        #50;
        check_now("hold_high", model_idx);
        clk_run = 1'b1;

        // Random run lengths with mid-scan resets in between.
        for (int r = 0; r < 6; r++) begin
            steps($urandom_range(1, 20));
            mid_scan_reset("rst_rand");
            step();
        end

`ifdef PIX_CTRL_SAFE_FSM_EN
        // Illegal one-hot pattern must recover to S0 on the next edge.
        @(negedge clk_480Hz);
        force dut.state = 8'b0000_0101;
        #1;
        release dut.state;
        @(posedge clk_480Hz);
        #1;
        check_now("illegal_recover", 3'd0);
        model_idx = 3'd0;
        step();
`endif

        check("sb_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
